// File: rtl/pkt_rr_scheduler_pkg.sv
// Shared constants for the packet round-robin scheduler.
// FIFO entry layout is {sop, eop, data}.
package pkt_rr_scheduler_pkg;

  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_NUM_PORTS     = 4;
  localparam int DEF_MAX_PKT_BEATS = 32;
  localparam int PORT_W            = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  function automatic int sop_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int eop_bit(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/pkt_rr_scheduler_arb.sv
// Combinational round-robin pick starting after last_grant.
// The parent owns and updates the pointer.
module rr_arbiter
  import pkt_rr_scheduler_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int IDX_W     = PORT_W
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    // farthest candidate first so the nearest one wins
    for (int off = NUM_PORTS; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % NUM_PORTS;
      if (req[idx]) begin
        gnt_idx = IDX_W'(idx);
        gnt_vld = 1'b1;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/pkt_rr_scheduler.sv
// Packet-granular RR scheduler: FIFOs -> one registered beat stream.
// Grant is held from sop to (possibly forced) eop.
module pkt_rr_scheduler
  import pkt_rr_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int NUM_PORTS     = DEF_NUM_PORTS,
  parameter int MAX_PKT_BEATS = DEF_MAX_PKT_BEATS
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic [NUM_PORTS-1:0]              i_fifo_empty,
  input  logic [NUM_PORTS*(DATA_WIDTH+2)-1:0] i_fifo_dout,
  output logic [NUM_PORTS-1:0]              o_fifo_rd_en,
  input  logic                              i_ready,
  output logic                              o_valid,
  output logic                              o_sop,
  output logic                              o_eop,
  output logic [DATA_WIDTH-1:0]             o_data,
  output logic [1:0]                        o_port,
  output logic                              o_pkt_err,
  output logic                              o_busy
);

  localparam int EW = DATA_WIDTH + 2;
  localparam int CW = $clog2(MAX_PKT_BEATS);
  localparam int SB = sop_bit(DATA_WIDTH);
  localparam int EB = eop_bit(DATA_WIDTH);

  logic [0:0]           state;
  logic [PORT_W-1:0]    grant;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [PORT_W-1:0]    last_grant;
  logic                 beat_vld;
  logic [CW-1:0]        count;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PORT_W-1:0]    arb_idx;
  logic                 arb_vld;

  logic [EW-1:0]        entry;
  logic                 beat_sop;
  logic                 beat_eop;
  logic                 first;
  logic                 last_beat;
  logic                 beat_eop_eff;
  logic                 beat_err;
  logic                 rd_en;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (PORT_W)
  ) u_arb (
    .req        (~i_fifo_empty),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .gnt_vld    (arb_vld)
  );

  always_comb begin
    entry        = i_fifo_dout[int'(grant)*EW +: EW];
    beat_sop     = entry[SB];
    beat_eop     = entry[EB];
    first        = (count == '0);
    last_beat    = (count == CW'(MAX_PKT_BEATS-1));
    beat_eop_eff = beat_eop | last_beat;
    beat_err     = (first & ~beat_sop)
                 | (~first & beat_sop)
                 | (last_beat & ~beat_eop);
  end

  // never read past the eop beat currently in flight
  always_comb begin
    rd_en = ~srst
          & (state == ST_XFER)
          & ~i_fifo_empty[grant]
          & i_ready
          & ~(beat_vld & beat_eop_eff);
    o_fifo_rd_en = rd_en ? grant_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      grant_oh   <= '0;
      last_grant <= PORT_W'(NUM_PORTS-1);
      o_busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            grant    <= arb_idx;
            grant_oh <= arb_gnt;
            o_busy   <= 1'b1;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (beat_vld && beat_eop_eff) begin
            last_grant <= grant;
            grant_oh   <= '0;
            o_busy     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      beat_vld  <= 1'b0;
      count     <= '0;
      o_valid   <= 1'b0;
      o_sop     <= 1'b0;
      o_eop     <= 1'b0;
      o_pkt_err <= 1'b0;
      o_data    <= '0;
      o_port    <= '0;
    end else begin
      beat_vld  <= rd_en;
      o_valid   <= beat_vld;
      o_sop     <= beat_vld & first;
      o_eop     <= beat_vld & beat_eop_eff;
      o_pkt_err <= beat_vld & beat_err;
      o_data    <= beat_vld ? entry[DATA_WIDTH-1:0] : '0;
      o_port    <= beat_vld ? 2'(grant) : 2'b0;
      if (beat_vld) begin
        count <= beat_eop_eff ? '0 : count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// Directed bench for pkt_rr_scheduler with behavioural FIFOs.
// Expected beats and flags are written out per scenario.
module tb_pkt_rr_scheduler;

  localparam int DW = 64;
  localparam int NP = 4;
  localparam int EW = DW + 2;

  typedef struct {
    logic [1:0]    port;
    logic          sop;
    logic          eop;
    logic          err;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int   cyc;
    int   port;
    logic rdy;
  } rd_t;

  logic             clk = 1'b0;
  logic             srst;
  logic [NP-1:0]    fifo_empty;
  logic [NP*EW-1:0] fifo_dout;
  logic [NP-1:0]    fifo_rd_en;
  logic             ready;
  logic             valid;
  logic             sop;
  logic             eop;
  logic [DW-1:0]    data;
  logic [1:0]       port;
  logic             pkt_err;
  logic             busy;

  logic [EW-1:0] mem [NP][128];
  logic [31:0]   wptr [NP];
  logic [31:0]   rptr [NP];

  beat_t obs[$];
  rd_t   rdq[$];
  int    cyc;
  int    multi;
  int    total;
  int    bad;

  always #5 clk = ~clk;

  pkt_rr_scheduler dut (
    .clk          (clk),
    .srst         (srst),
    .i_fifo_empty (fifo_empty),
    .i_fifo_dout  (fifo_dout),
    .o_fifo_rd_en (fifo_rd_en),
    .i_ready      (ready),
    .o_valid      (valid),
    .o_sop        (sop),
    .o_eop        (eop),
    .o_data       (data),
    .o_port       (port),
    .o_pkt_err    (pkt_err),
    .o_busy       (busy)
  );

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      fifo_empty[p] = (wptr[p] == rptr[p]);
    end
  end

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (srst) begin
        rptr[p] <= wptr[p];
      end else if (fifo_rd_en[p]) begin
        fifo_dout[p*EW +: EW] <= mem[p][rptr[p][6:0]];
        rptr[p] <= rptr[p] + 1;
      end
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid) obs.push_back('{port, sop, eop, pkt_err, data});
    if ($countones(fifo_rd_en) > 1) multi <= multi + 1;
    for (int p = 0; p < NP; p++) begin
      if (fifo_rd_en[p]) rdq.push_back('{cyc, p, ready});
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(int t, int p, int k);
    return DW'(t * 4096 + p * 256 + k);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int p, input logic s,
                      input logic e, input logic [DW-1:0] d);
    mem[p][wptr[p][6:0]] = {s, e, d};
    wptr[p] = wptr[p] + 1;
  endtask

  task automatic wait_obs(input int n, input int budget,
                          input string tag);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    if (obs.size() < n) check(tag, 64'(obs.size()), 64'(n));
  endtask

  task automatic chk_beat(input string tag, input int i,
                          input int p, input logic s,
                          input logic e, input logic r,
                          input logic [DW-1:0] d);
    if (i >= obs.size()) begin
      check(tag, 64'(obs.size()), 64'(i + 1));
    end else begin
      check(tag, {obs[i].port, obs[i].sop, obs[i].eop, obs[i].err},
            {2'(p), s, e, r});
      check(tag, obs[i].data, d);
    end
  endtask

  task automatic chk_quiet(input string tag);
    check(tag, {valid, sop, eop, pkt_err, busy, port, fifo_rd_en}, 0);
    check(tag, data, 0);
  endtask

  task automatic do_reset;
    srst = 1'b1;
    tick(2);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;
    srst = 1'b0;
  endtask

  initial begin
    int b;
    int rb;
    int n;
    int ok;
    logic s;
    logic e;
    logic r;
    total = 0;
    bad   = 0;
    cyc   = 0;
    multi = 0;
    srst  = 1'b1;
    ready = 1'b1;
    for (int p = 0; p < NP; p++) wptr[p] = 0;
    do_reset();
    tick(3);
    chk_quiet("idle_all_empty");

    // single 3-beat packet on port 2
    b  = obs.size();
    rb = rdq.size();
    push(2, 1, 0, dat(1, 2, 0));
    push(2, 0, 0, dat(1, 2, 1));
    push(2, 0, 1, dat(1, 2, 2));
    wait_obs(b + 3, 20, "t1_timeout");
    tick(6);
    check("t1_nbeats", 64'(obs.size() - b), 3);
    chk_beat("t1_b0", b + 0, 2, 1, 0, 0, dat(1, 2, 0));
    chk_beat("t1_b1", b + 1, 2, 0, 0, 0, dat(1, 2, 1));
    chk_beat("t1_b2", b + 2, 2, 0, 1, 0, dat(1, 2, 2));
    check("t1_nreads", 64'(rdq.size() - rb), 3);
    if (rdq.size() - rb == 3) begin
      check("t1_rdport", 64'(rdq[rb].port + rdq[rb+2].port), 4);
      check("t1_consec", 64'(rdq[rb+2].cyc - rdq[rb].cyc), 2);
    end

    // three simultaneous requesters, late port-0 arrival
    do_reset();
    b = obs.size();
    for (int k = 0; k < 2; k++) begin
      push(0, k == 0, k == 1, dat(2, 0, k));
      push(1, k == 0, k == 1, dat(2, 1, k));
      push(3, k == 0, k == 1, dat(2, 3, k));
    end
    n = 0;
    while (!(obs.size() > b && obs[obs.size()-1].port == 2'd3)
           && n < 40) begin
      tick(1);
      n++;
    end
    check("t2_p3_seen", 64'(n < 40), 1);
    push(0, 1, 0, dat(2, 0, 8));
    push(0, 0, 1, dat(2, 0, 9));
    wait_obs(b + 8, 40, "t2_timeout");
    tick(6);
    check("t2_nbeats", 64'(obs.size() - b), 8);
    chk_beat("t2_b0", b + 0, 0, 1, 0, 0, dat(2, 0, 0));
    chk_beat("t2_b1", b + 1, 0, 0, 1, 0, dat(2, 0, 1));
    chk_beat("t2_b2", b + 2, 1, 1, 0, 0, dat(2, 1, 0));
    chk_beat("t2_b3", b + 3, 1, 0, 1, 0, dat(2, 1, 1));
    chk_beat("t2_b4", b + 4, 3, 1, 0, 0, dat(2, 3, 0));
    chk_beat("t2_b5", b + 5, 3, 0, 1, 0, dat(2, 3, 1));
    chk_beat("t2_b6", b + 6, 0, 1, 0, 0, dat(2, 0, 8));
    chk_beat("t2_b7", b + 7, 0, 0, 1, 0, dat(2, 0, 9));

    // 4-beat packet on port 1 with toggling ready
    b  = obs.size();
    rb = rdq.size();
    for (int k = 0; k < 4; k++) push(1, k == 0, k == 3, dat(3, 1, k));
    for (int k = 0; k < 40; k++) begin
      tick(1);
      ready = ~ready;
    end
    ready = 1'b1;
    tick(4);
    check("t3_nbeats", 64'(obs.size() - b), 4);
    for (int k = 0; k < 4; k++) begin
      chk_beat("t3_beat", b + k, 1, k == 0, k == 3, 0, dat(3, 1, k));
    end
    check("t3_nreads", 64'(rdq.size() - rb), 4);
    ok = 1;
    for (int i = rb; i < rdq.size(); i++) begin
      if (rdq[i].rdy !== 1'b1 || rdq[i].port != 1) ok = 0;
    end
    check("t3_rd_only_ready", 64'(ok), 1);

    // 40-beat port-1 stream, eop only on the last entry
    b = obs.size();
    for (int k = 0; k < 40; k++) push(1, k == 0, k == 39, dat(4, 1, k));
    wait_obs(b + 40, 120, "t4_timeout");
    tick(6);
    check("t4_nbeats", 64'(obs.size() - b), 40);
    for (int k = 0; k < 40; k++) begin
      s = (k == 0) || (k == 32);
      e = (k == 31) || (k == 39);
      r = (k == 31) || (k == 32);
      chk_beat("t4_beat", b + k, 1, s, e, r, dat(4, 1, k));
    end
    check("t4_idle_after", {busy, valid}, 0);

    // missing sop on entry 0, stray sop on entry 2
    b = obs.size();
    push(2, 0, 0, dat(5, 2, 0));
    push(2, 0, 0, dat(5, 2, 1));
    push(2, 1, 0, dat(5, 2, 2));
    push(2, 0, 1, dat(5, 2, 3));
    wait_obs(b + 4, 30, "t5_timeout");
    tick(6);
    check("t5_nbeats", 64'(obs.size() - b), 4);
    chk_beat("t5_b0", b + 0, 2, 1, 0, 1, dat(5, 2, 0));
    chk_beat("t5_b1", b + 1, 2, 0, 0, 0, dat(5, 2, 1));
    chk_beat("t5_b2", b + 2, 2, 0, 0, 1, dat(5, 2, 2));
    chk_beat("t5_b3", b + 3, 2, 0, 1, 0, dat(5, 2, 3));

    // reset during beat 2 of a 5-beat port-3 packet
    b = obs.size();
    for (int k = 0; k < 5; k++) push(3, k == 0, k == 4, dat(6, 3, k));
    wait_obs(b + 1, 30, "t6_timeout");
    check("t6_beat2_live", {valid, port}, {1'b1, 2'd3});
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("t6_abort");
    @(posedge clk);
    #1;
    srst = 1'b0;
    tick(4);
    chk_quiet("t6_after_rel");
    b = obs.size();
    push(3, 1, 1, dat(6, 3, 9));
    push(0, 1, 1, dat(6, 0, 9));
    wait_obs(b + 2, 30, "t6b_timeout");
    tick(8);
    check("t6_nbeats", 64'(obs.size() - b), 2);
    chk_beat("t6_first", b + 0, 0, 1, 1, 0, dat(6, 0, 9));
    chk_beat("t6_second", b + 1, 3, 1, 1, 0, dat(6, 3, 9));
    check("multi_rd", 64'(multi), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
